// File: rtl/alu_issue_arbiter.sv
// Two-port arbiter feeding the shared ALU: one issue register stage, one result stage,
// and the architectural NZCV register (N=bit3, Z=bit2, C=bit1, V=bit0).
module alu_issue_arbiter #(
    parameter int FIXED_PRIO = 0,
    parameter int DATA_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [4:0]        req0_uop,
    input  logic [4:0]        req1_uop,
    input  logic [DATA_W-1:0] req0_lhs,
    input  logic [DATA_W-1:0] req1_lhs,
    input  logic [DATA_W-1:0] req0_rhs,
    input  logic [DATA_W-1:0] req1_rhs,
    input  logic              req0_setf,
    input  logic              req1_setf,
    output logic [1:0]        resp_valid,
    output logic [DATA_W-1:0] resp_result,
    output logic              resp_err,
    output logic [3:0]        flags_q
);

    typedef enum logic [4:0] {
        UOP_ADD = 5'd0,
        UOP_SUB = 5'd1,
        UOP_AND = 5'd2,
        UOP_EOR = 5'd3,
        UOP_CMP = 5'd4,
        UOP_LSL = 5'd5,
        UOP_LSR = 5'd6,
        UOP_MOV = 5'd7,
        UOP_STR = 5'd8,
        UOP_LDR = 5'd9
    } uop_e;

    localparam int MSB  = DATA_W - 1;
    localparam int SH_W = $clog2(DATA_W);

    logic [1:0]        grant;
    logic              accept;
    logic              last_port;

    logic              s1_valid;
    logic              s1_id;
    logic [4:0]        s1_uop;
    logic [DATA_W-1:0] s1_lhs;
    logic [DATA_W-1:0] s1_rhs;
    logic              s1_setf;

    logic [4:0]        sel_uop;
    logic [DATA_W-1:0] sel_lhs;
    logic [DATA_W-1:0] sel_rhs;
    logic              sel_setf;

    logic [DATA_W:0]   sum_add;
    logic [DATA_W:0]   sum_sub;
    logic [DATA_W-1:0] alu_res;
    logic              alu_c;
    logic              alu_v;
    logic              alu_ok;
    logic [3:0]        alu_flags;

    // last_port == 1 means port 1 was granted most recently, so port 0 wins a tie
    always_comb begin
        grant = '0;
        if (!rst && !flush) begin
            case (req_valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = (FIXED_PRIO != 0 || last_port) ? 2'b01 : 2'b10;
                default: grant = '0;
            endcase
        end
    end

    assign req_ready = grant;
    assign accept    = |grant;

    always_comb begin
        sel_uop  = grant[1] ? req1_uop  : req0_uop;
        sel_lhs  = grant[1] ? req1_lhs  : req0_lhs;
        sel_rhs  = grant[1] ? req1_rhs  : req0_rhs;
        sel_setf = grant[1] ? req1_setf : req0_setf;
    end

    // C on subtract is "no borrow"; logic, shift and move ops clear C and V
    always_comb begin
        sum_add = {1'b0, s1_lhs} + {1'b0, s1_rhs};
        sum_sub = {1'b0, s1_lhs} + {1'b0, ~s1_rhs} + (DATA_W+1)'(1);
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_ok  = 1'b1;
        case (s1_uop)
            UOP_ADD, UOP_STR, UOP_LDR: begin
                alu_res = sum_add[MSB:0];
                alu_c   = sum_add[DATA_W];
                alu_v   = (s1_lhs[MSB] == s1_rhs[MSB]) && (sum_add[MSB] != s1_lhs[MSB]);
            end
            UOP_SUB, UOP_CMP: begin
                alu_res = sum_sub[MSB:0];
                alu_c   = sum_sub[DATA_W];
                alu_v   = (s1_lhs[MSB] != s1_rhs[MSB]) && (sum_sub[MSB] != s1_lhs[MSB]);
            end
            UOP_AND: alu_res = s1_lhs & s1_rhs;
            UOP_EOR: alu_res = s1_lhs ^ s1_rhs;
            UOP_LSL: alu_res = s1_lhs << s1_rhs[SH_W-1:0];
            UOP_LSR: alu_res = s1_lhs >> s1_rhs[SH_W-1:0];
            UOP_MOV: alu_res = s1_rhs;
            default: alu_ok  = 1'b0;
        endcase
        alu_flags = {alu_res[MSB], (alu_res == '0), alu_c, alu_v};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid    <= 1'b0;
            s1_id       <= 1'b0;
            s1_uop      <= '0;
            s1_lhs      <= '0;
            s1_rhs      <= '0;
            s1_setf     <= 1'b0;
            last_port   <= 1'b1;
            resp_valid  <= '0;
            resp_result <= '0;
            resp_err    <= 1'b0;
            flags_q     <= '0;
        end else begin
            // grant is forced to zero under flush, so this also empties S1 on a flush edge
            s1_valid <= accept;
            if (accept) begin
                s1_id     <= grant[1];
                s1_uop    <= sel_uop;
                s1_lhs    <= sel_lhs;
                s1_rhs    <= sel_rhs;
                s1_setf   <= sel_setf;
                last_port <= grant[1];
            end
            resp_valid <= '0;
            if (s1_valid && !flush) begin
                resp_valid  <= s1_id ? 2'b10 : 2'b01;
                resp_result <= alu_ok ? alu_res : '0;
                resp_err    <= !alu_ok;
                if (alu_ok && s1_setf) begin
                    flags_q <= alu_flags;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Scoreboard bench: stimulus pushes expected responses, monitors pop and compare.
module tb_alu_issue_arbiter;

    localparam logic [4:0] ADD = 5'd0, SUB = 5'd1, AND_ = 5'd2, EOR = 5'd3, CMP = 5'd4;
    localparam logic [4:0] LSL = 5'd5, LSR = 5'd6, MOV = 5'd7, STR = 5'd8, LDR = 5'd9;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic [1:0]  vld0 = '0;
    logic [1:0]  vldf = '0;
    logic [4:0]  u0 = '0, u1 = '0;
    logic [31:0] l0 = '0, l1 = '0, r0 = '0, r1 = '0;
    logic        s0 = 1'b0, s1 = 1'b0;

    logic [1:0]  rdy0, rdyf, rv0, rvf;
    logic [31:0] res0, resf;
    logic        err0, errf;
    logic [3:0]  flg0, flgf;

    typedef struct {
        logic [1:0]  vld;
        logic [31:0] res;
        logic        err;
        logic [3:0]  flg;
        int          due;
    } exp_t;

    exp_t q0[$];
    exp_t qf[$];
    int   n_chk = 0;
    int   n_pass = 0;
    int   cyc_n = 0;

    alu_issue_arbiter #(.FIXED_PRIO(0), .DATA_W(32)) dut_rr (
        .clk(clk), .rst(rst), .flush(flush), .req_valid(vld0), .req_ready(rdy0),
        .req0_uop(u0), .req1_uop(u1), .req0_lhs(l0), .req1_lhs(l1),
        .req0_rhs(r0), .req1_rhs(r1), .req0_setf(s0), .req1_setf(s1),
        .resp_valid(rv0), .resp_result(res0), .resp_err(err0), .flags_q(flg0)
    );

    alu_issue_arbiter #(.FIXED_PRIO(1), .DATA_W(32)) dut_fx (
        .clk(clk), .rst(rst), .flush(flush), .req_valid(vldf), .req_ready(rdyf),
        .req0_uop(u0), .req1_uop(u1), .req0_lhs(l0), .req1_lhs(l1),
        .req0_rhs(r0), .req1_rhs(r1), .req0_setf(s0), .req1_setf(s1),
        .resp_valid(rvf), .resp_result(resf), .resp_err(errf), .flags_q(flgf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic drive(input int p, input logic [4:0] u, input logic [31:0] l, input logic [31:0] r,
                         input logic s);
        if (p == 0) begin u0 = u; l0 = l; r0 = r; s0 = s; end
        else        begin u1 = u; l1 = l; r1 = r; s1 = s; end
    endtask

    task automatic push0(input logic [1:0] v, input logic [31:0] res, input logic err, input logic [3:0] f);
        q0.push_back('{vld: v, res: res, err: err, flg: f, due: cyc_n + 2});
    endtask

    // single-port op on the round-robin DUT; entered and left at posedge+1
    task automatic issue1(input int p, input logic [4:0] u, input logic [31:0] l, input logic [31:0] r,
                          input logic s, input logic [31:0] eres, input logic eerr, input logic [3:0] ef);
        logic [1:0] oh;
        oh = (p == 0) ? 2'b01 : 2'b10;
        drive(p, u, l, r, s);
        vld0 = oh;
        @(negedge clk);
        check("ready_single", {30'd0, rdy0}, {30'd0, oh});
        push0(oh, eres, eerr, ef);
        @(posedge clk); #1;
        vld0 = '0;
    endtask

    initial begin : mon_rr
        exp_t e;
        forever begin
            @(negedge clk);
            if (rv0 != 2'b00) begin
                if (q0.size() == 0) check("rr_unexpected_resp", {30'd0, rv0}, 32'd0);
                else begin
                    e = q0.pop_front();
                    check("rr_resp_valid", {30'd0, rv0}, {30'd0, e.vld});
                    check("rr_result", res0, e.res);
                    check("rr_err", {31'd0, err0}, {31'd0, e.err});
                    check("rr_flags", {28'd0, flg0}, {28'd0, e.flg});
                    check("rr_latency", cyc_n, e.due);
                end
            end
        end
    end

    initial begin : mon_fx
        exp_t e;
        forever begin
            @(negedge clk);
            if (rvf != 2'b00) begin
                if (qf.size() == 0) check("fx_unexpected_resp", {30'd0, rvf}, 32'd0);
                else begin
                    e = qf.pop_front();
                    check("fx_resp_valid", {30'd0, rvf}, {30'd0, e.vld});
                    check("fx_result", resf, e.res);
                    check("fx_flags", {28'd0, flgf}, {28'd0, e.flg});
                    check("fx_latency", cyc_n, e.due);
                end
            end
        end
    end

    initial begin : stim
        logic [4:0]  p0u[2], p1u[2];
        logic [31:0] p0l[2], p0r[2], p0x[2], p1l[2], p1r[2], p1x[2];
        logic [1:0]  gexp;
        int i0, i1;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_flags", {28'd0, flg0}, 32'd0);
        check("reset_resp_valid", {30'd0, rv0}, 32'd0);
        check("reset_result", res0, 32'd0);
        check("reset_err", {31'd0, err0}, 32'd0);
        check("reset_ready_idle", {30'd0, rdy0}, 32'd0);
        @(posedge clk); #1;

        // signed overflow into N and V
        issue1(0, ADD, 32'h7FFF_FFFF, 32'h1, 1'b1, 32'h8000_0000, 1'b0, 4'b1001);
        // unsupported uop: zero result, err, flags untouched despite setf
        issue1(1, 5'h1F, 32'h1234, 32'h5678, 1'b1, 32'h0, 1'b1, 4'b1001);

        // round-robin with both ports saturating: last grant was port 1
        p0u = '{ADD, SUB};  p0l = '{32'd1, 32'd10};      p0r = '{32'd2, 32'd3};    p0x = '{32'd3, 32'd7};
        p1u = '{STR, LDR};  p1l = '{32'h1000, 32'h2000}; p1r = '{32'h20, 32'h4};   p1x = '{32'h1020, 32'h2004};
        i0 = 0; i1 = 0;
        for (int c = 0; c < 4; c++) begin
            drive(0, p0u[i0], p0l[i0], p0r[i0], 1'b0);
            drive(1, p1u[i1], p1l[i1], p1r[i1], 1'b0);
            vld0 = 2'b11;
            gexp = (c % 2 == 0) ? 2'b01 : 2'b10;
            @(negedge clk);
            check("rr_grant", {30'd0, rdy0}, {30'd0, gexp});
            if (gexp == 2'b01) begin push0(2'b01, p0x[i0], 1'b0, 4'b1001); i0++; end
            else               begin push0(2'b10, p1x[i1], 1'b0, 4'b1001); i1++; end
            @(posedge clk); #1;
        end
        vld0 = '0;
        repeat (3) @(posedge clk); #1;

        // fixed priority: port 0 wins every cycle while it keeps requesting
        drive(1, STR, 32'h1000, 32'h20, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            drive(0, ADD, k, k, 1'b0);
            vldf = 2'b11;
            @(negedge clk);
            check("fx_grant_p0", {30'd0, rdyf}, 32'd1);
            qf.push_back('{vld: 2'b01, res: 2 * k, err: 1'b0, flg: 4'b0000, due: cyc_n + 2});
            @(posedge clk); #1;
        end
        vldf = 2'b10;
        @(negedge clk);
        check("fx_grant_p1", {30'd0, rdyf}, 32'd2);
        qf.push_back('{vld: 2'b10, res: 32'h1020, err: 1'b0, flg: 4'b0000, due: cyc_n + 2});
        @(posedge clk); #1;
        vldf = '0;
        repeat (3) @(posedge clk); #1;

        // flag commit only with setf
        issue1(0, EOR, 32'h55, 32'h55, 1'b0, 32'h0, 1'b0, 4'b1001);
        issue1(0, LSL, 32'h1, 32'd4, 1'b0, 32'h10, 1'b0, 4'b1001);
        issue1(0, LSR, 32'h80, 32'd3, 1'b0, 32'h10, 1'b0, 4'b1001);
        issue1(0, AND_, 32'hF0, 32'h3C, 1'b1, 32'h30, 1'b0, 4'b0000);
        issue1(0, CMP, 32'd5, 32'd5, 1'b1, 32'h0, 1'b0, 4'b0110);
        issue1(0, CMP, 32'd3, 32'd5, 1'b0, 32'hFFFF_FFFE, 1'b0, 4'b0110);
        issue1(0, CMP, 32'd5, 32'd5, 1'b0, 32'h0, 1'b0, 4'b0110);

        // flush kills the in-flight MOV and blocks the retry for one cycle
        drive(0, MOV, 32'h0, 32'hAA, 1'b1);
        vld0 = 2'b01;
        @(negedge clk);
        check("flush_first_accept", {30'd0, rdy0}, 32'd1);
        @(posedge clk); #1;
        flush = 1'b1;
        @(negedge clk);
        check("flush_ready_blocked", {30'd0, rdy0}, 32'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        check("flush_flags_kept", {28'd0, flg0}, 32'h6);
        check("flush_retry_ready", {30'd0, rdy0}, 32'd1);
        push0(2'b01, 32'hAA, 1'b0, 4'b0000);
        @(posedge clk); #1;
        vld0 = '0;
        repeat (3) @(posedge clk); #1;

        // reset while an op sits in S1
        drive(0, ADD, 32'd1, 32'd1, 1'b1);
        vld0 = 2'b01;
        @(negedge clk);
        check("rst_pre_accept", {30'd0, rdy0}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        vld0 = '0;
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_flags_cleared", {28'd0, flg0}, 32'd0);
        check("rst_no_resp", {30'd0, rv0}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        drive(0, MOV, 32'h0, 32'h11, 1'b0);
        drive(1, MOV, 32'h0, 32'h22, 1'b0);
        vld0 = 2'b11;
        @(negedge clk);
        check("rst_first_tie_p0", {30'd0, rdy0}, 32'd1);
        push0(2'b01, 32'h11, 1'b0, 4'b0000);
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_second_tie_p1", {30'd0, rdy0}, 32'd2);
        push0(2'b10, 32'h22, 1'b0, 4'b0000);
        @(posedge clk); #1;
        vld0 = '0;

        repeat (6) @(posedge clk);
        @(negedge clk);
        check("rr_queue_drained", q0.size(), 32'd0);
        check("fx_queue_drained", qf.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
